// File: rtl/fpu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_seq_ctrl_pkg
// Shared constants for the OP-FP decode and sequencing path:
//   - OP-FP major opcode
//   - funct5 codes of the FP operation classes
//   - FSM state encoding of the FPU sequencing controller
//   - in-flight operation record and the x0 helper
// The main decoder imports this package as well, so all encodings live here.
// ---------------------------------------------------------------------------
package fpu_seq_ctrl_pkg;

    // Major opcode of every FP compute instruction.
    localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;

    // funct5 codes (instr[31:27]) of the operation classes.
    localparam logic [4:0] FADD     = 5'b00000;
    localparam logic [4:0] FSUB     = 5'b00001;
    localparam logic [4:0] FMUL     = 5'b00010;
    localparam logic [4:0] FDIV     = 5'b00011;
    localparam logic [4:0] FSQRT    = 5'b01011;
    localparam logic [4:0] FCVT_W_S = 5'b11000;
    localparam logic [4:0] FCVT_S_W = 5'b11010;
    localparam logic [4:0] FMV_X_W  = 5'b11100;
    localparam logic [4:0] FMV_W_X  = 5'b11110;

    // Sequencer state encoding (kept as plain constants so legacy code that
    // compares raw state bits keeps working).
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_EXEC = 2'd1;
    localparam fsm_state_t ST_WB   = 2'd2;

    // Operation captured at issue and held until writeback or flush.
    typedef struct packed {
        logic [4:0] op;
        logic [4:0] rd;
        logic       rd_int;
    } fp_op_t;

    // Integer x0 is hard-wired zero: never written, never a hazard source.
    // F register f0 is a real register, so rd_int must be part of the test.
    function automatic logic is_int_x0(input logic rd_int, input logic [4:0] rd);
        return rd_int && (rd == 5'd0);
    endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// ---------------------------------------------------------------------------
// fpu_lat_lut
// Combinational funct5 -> execution latency lookup for the shared FPU.
// Ports:
//   funct5 in  [4:0]        operation class of the issuing instruction
//   lat    out [CNT_W-1:0]  execution latency in cycles (>= 1)
// ---------------------------------------------------------------------------
module fpu_lat_lut
    import fpu_seq_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned CNT_W    = 5
) (
    input  logic [4:0]       funct5,
    output logic [CNT_W-1:0] lat
);

    always_comb begin
        // NOTE: default first so every path assigns lat and no latch is inferred.
        lat = CNT_W'(LAT_MISC);
        case (funct5)
            FADD, FSUB: lat = CNT_W'(LAT_ADD);
            FMUL:       lat = CNT_W'(LAT_MUL);
            FDIV:       lat = CNT_W'(LAT_DIV);
            FSQRT:      lat = CNT_W'(LAT_SQRT);
            default:    lat = CNT_W'(LAT_MISC);  // conversions, moves, others
        endcase
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_seq_ctrl
// Sequencing controller for the shared, non-pipelined FPU. Accepts one FP op
// at a time, times it by operation class, arbitrates for the writeback port
// shared with loads, and exposes a one-entry scoreboard for decode stalls.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   issue_valid/issue_ready            issue handshake (accept in IDLE only)
//   issue_funct5/issue_rd/issue_rd_int decoded op, destination, dest RF select
//   flush                              kills the in-flight op
//   fpu_start                          one-cycle launch pulse to the FPU
//   fpu_op                             funct5 held while the op is in flight
//   wb_req/wb_grant                    writeback port request/grant
//   wb_rd                              writeback destination index
//   wb_we_int/wb_we_f                  integer / F register file write enables
//   haz_rs1..3, haz_rs_int             sources of the instruction in decode
//   haz_stall                          RAW hazard against pending destination
// ---------------------------------------------------------------------------
module fpu_seq_ctrl
    import fpu_seq_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [4:0] issue_funct5,
    input  logic [4:0] issue_rd,
    input  logic       issue_rd_int,
    input  logic       flush,
    output logic       fpu_start,
    output logic [4:0] fpu_op,
    output logic       wb_req,
    input  logic       wb_grant,
    output logic [4:0] wb_rd,
    output logic       wb_we_int,
    output logic       wb_we_f,
    input  logic [4:0] haz_rs1,
    input  logic [4:0] haz_rs2,
    input  logic [4:0] haz_rs3,
    input  logic       haz_rs_int,
    output logic       haz_stall
);

    fsm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    fp_op_t           cur;
    logic [CNT_W-1:0] lat;
    logic             accept;
    logic             wb_fire;
    logic             rd_x0;
    logic             src_match;

    fpu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_MISC (LAT_MISC),
        .CNT_W    (CNT_W)
    ) u_lat_lut (
        .funct5 (issue_funct5),
        .lat    (lat)
    );

    assign accept = (state == ST_IDLE) && issue_valid && !flush;

    // The counter holds the cycles still to run, counting the issue cycle as
    // the first one. It is loaded with latency-1 and reaches 0 on entry to
    // WB, so an op issued in cycle N raises wb_req in cycle N+latency.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            cur   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur   <= '{op: issue_funct5, rd: issue_rd, rd_int: issue_rd_int};
                        cnt   <= lat - CNT_W'(1);
                        pend  <= 1'b1;
                        // Single-cycle ops skip EXEC entirely.
                        state <= (lat <= CNT_W'(1)) ? ST_WB : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        pend  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt <= CNT_W'(1)) begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (flush || wb_grant) begin
                        state <= ST_IDLE;
                        pend  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pend  <= 1'b0;
                end
            endcase
        end
    end

    // A flush in the grant cycle suppresses the write.
    assign wb_fire = (state == ST_WB) && wb_grant && !flush;
    assign rd_x0   = is_int_x0(cur.rd_int, cur.rd);

    assign issue_ready = (state == ST_IDLE);
    // Gated by rst_n so a held issue_valid cannot pulse the FPU during reset.
    assign fpu_start   = accept && rst_n;
    assign fpu_op      = cur.op;
    assign wb_req      = (state == ST_WB);
    assign wb_rd       = cur.rd;
    assign wb_we_int   = wb_fire && cur.rd_int && !rd_x0;
    assign wb_we_f     = wb_fire && !cur.rd_int;

    assign src_match = (haz_rs1 == cur.rd) || (haz_rs2 == cur.rd) || (haz_rs3 == cur.rd);
    assign haz_stall = pend && (haz_rs_int == cur.rd_int) && !rd_x0 && src_match;

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
Sequencing controller for the shared, non-pipelined FPU datapath behind the OP-FP (1010011) decode path. Accepts one decoded FP operation at a time with a valid/ready handshake and times its execution with a per-class latency counter. Arbitrates for the shared writeback port, which it shares with load writeback, and exposes a one-entry scoreboard so decode can stall on RAW hazards against the in-flight destination. Sits between decode/issue and the FPU, and drives DSrc-side writeback qualifiers.

Parameters:
LAT_ADD, 3, cycles for fadd/fsub (funct5 00000/00001)
LAT_MUL, 4, cycles for fmul (00010)
LAT_DIV, 12, cycles for fdiv (00011)
LAT_SQRT, 16, cycles for fsqrt (01011)
LAT_MISC, 1, cycles for fcvt/fmv (11000/11010/11100/11110) and all other funct5
CNT_W, 5, latency counter width; must hold max latency

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decoded FP op present
issue_ready  out  1  controller can accept op
issue_funct5  in  5  instruction funct5
issue_rd  in  5  destination register index
issue_rd_int  in  1  1 = destination in integer RF (fcvt.w.s, fmv.x.w), 0 = F RF
flush  in  1  pipeline flush; kills in-flight op
fpu_start  out  1  one-cycle launch pulse to FPU
fpu_op  out  5  funct5 latched at issue, stable while busy
wb_req  out  1  result ready, requesting writeback port
wb_grant  in  1  writeback port granted this cycle
wb_rd  out  5  destination index for writeback
wb_we_int  out  1  integer RF write enable (wb_req & wb_grant & rd_int)
wb_we_f  out  1  F RF write enable (wb_req & wb_grant & ~rd_int)
haz_rs1, haz_rs2, haz_rs3  in  5 each  source indices of instruction in decode
haz_rs_int  in  1  sources of decode instruction read the integer RF
haz_stall  out  1  RAW hazard against pending destination

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter 0; issue_ready=1; fpu_start=0; wb_req=0; wb_we_*=0; fpu_op=0; wb_rd=0; haz_stall=0; pending-valid flag cleared.
- States: IDLE, EXEC, WB.
- IDLE: issue_ready=1. On issue_valid & ~flush: latch funct5, rd, rd_int; load counter with class latency minus 1; assert fpu_start for exactly that cycle; set pending-valid; go to EXEC.
- Fast path: if latency=1, go directly to WB on the following cycle.
- EXEC: issue_ready=0; counter decrements each cycle. At 0, go to WB the next cycle.
- WB: wb_req=1. When wb_grant=1, write enables fire combinationally that cycle; go to IDLE next cycle and clear pending-valid. While wb_grant=0, hold in WB indefinitely; wb_rd and fpu_op stay stable.
- Back-to-back issue: issue_ready stays 0 in WB. A new op is accepted only in IDLE, so minimum spacing is latency+1 cycles.
- Issue latency: an op issued at cycle N with latency L asserts wb_req first at N+L.
- flush: in EXEC or WB, return to IDLE next cycle and clear pending-valid. No write enable fires in the flush cycle, even if wb_grant=1. In IDLE, flush blocks acceptance that cycle.
- haz_stall (combinational) = pending-valid & (haz_rs_int == rd_int) & any(haz_rsX == rd).
- x0 rule: an integer rd of 0 never raises haz_stall and never asserts wb_we_int. The F register f0 is a real register and is tracked.
- wb_grant while not in WB is ignored.
- Reset asserted mid-operation aborts immediately; no write-enable glitch after rst_n falls.

Decomposition:
- Shared package holds: funct5 class constants (FADD, FSUB, FMUL, FDIV, FSQRT, FCVT_S_W, FCVT_W_S, FMV_W_X, FMV_X_W), the state encoding, and the OP-FP opcode constant. The main decoder also uses this package.
- One natural sub-module: fpu_lat_lut, a combinational funct5 -> latency lookup parameterised by the LAT_* values.

Test Plan:
- fadd rd=f5 issued at cycle 10, wb_grant tied 1 -> fpu_start at 10 only; wb_req and wb_we_f at 13 with wb_rd=5; issue_ready back to 1 at 14.
- fdiv rd=f7, wb_grant held 0 for 5 cycles after completion -> wb_req held from cycle 12 after issue; wb_rd=7 stable; wb_we_f only in the first grant cycle.
- fcvt.w.s rd=x3 (rd_int=1) -> latency 1; wb_we_int=1, wb_we_f=0. Same op with rd=x0 -> no write enable, haz_stall never set.
- fmul rd=f2 in flight, decode haz_rs2=2 with haz_rs_int=0 -> haz_stall=1. With haz_rs_int=1 -> haz_stall=0.
- fsqrt in flight, flush at counter=8 -> IDLE next cycle; no wb_req; haz_stall drops; a new op is accepted in the following cycle.
- rst_n pulled low during WB with wb_grant=1 -> all outputs at reset values immediately; no write enable observed.
